// File: rtl/ad_ip_jesd204_tpl_dac_pattern_channel.sv
// ad_ip_jesd204_tpl_dac_pattern_channel
// Per-converter DAC source mux: DDS, DMA, pattern, ramp, PN7/15/31 or zero.
module ad_ip_jesd204_tpl_dac_pattern_channel #(
  parameter int DATA_PATH_WIDTH      = 4,
  parameter int CONVERTER_RESOLUTION = 16,
  parameter bit SEL_ON_SYNC          = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dac_data_sync,
  input  logic [3:0]                    dac_data_sel,
  input  logic [15:0]                   dac_pat_data_0,
  input  logic [15:0]                   dac_pat_data_1,
  input  logic [15:0]                   dac_ramp_incr,
  input  logic [DATA_PATH_WIDTH*16-1:0] dds_data,
  input  logic [DATA_PATH_WIDTH*16-1:0] dma_data,
  input  logic                          dma_valid,
  output logic                          dma_ready,
  input  logic                          dac_underflow_clr,
  output logic [DATA_PATH_WIDTH*16-1:0] dac_data,
  output logic                          dac_enable,
  output logic                          dac_underflow
);
  localparam int DPW = DATA_PATH_WIDTH;
  localparam int DW  = DPW * 16;
  localparam int EW  = DW + 31;
  localparam int W7  = (DW > 7)  ? DW : 7;
  localparam int W15 = (DW > 15) ? DW : 15;
  localparam int W31 = (DW > 31) ? DW : 31;
  localparam logic [15:0] MASK =
    16'hffff << (16 - CONVERTER_RESOLUTION);

  // Low bits of s are the newest stream bits; returns DW new bits
  // in e[DW-1:0], first-generated bit at the MSB.
  function automatic logic [EW-1:0] pn_step(
    input logic [EW-1:0] s,
    input int            l,
    input int            t
  );
    logic [EW-1:0] e;
    e = '0;
    for (int i = 0; i < 31; i++)
      if (i < l) e[DW+i] = s[i];
    for (int i = DW - 1; i >= 0; i--)
      e[i] = e[i+l] ^ e[i+t];
    return e;
  endfunction

  logic [3:0]     sel_q;
  logic [W7-1:0]  pn7_q;
  logic [W15-1:0] pn15_q;
  logic [W31-1:0] pn31_q;
  logic [15:0]    ramp_q;
  logic [15:0]    ramp_d;
  logic [DW-1:0]  data_q;
  logic [DW-1:0]  data_d;
  logic           en_q;
  logic           unf_q;
  logic [EW-1:0]  pn7_e;
  logic [EW-1:0]  pn15_e;
  logic [EW-1:0]  pn31_e;
  logic [DW-1:0]  pn7_v;
  logic [DW-1:0]  pn15_v;
  logic [DW-1:0]  pn31_v;
  logic [15:0]    lane;
  logic           dma_sel;

  assign pn7_e  = pn_step(EW'(pn7_q), 7, 6);
  assign pn15_e = pn_step(EW'(pn15_q), 15, 14);
  assign pn31_e = pn_step(EW'(pn31_q), 31, 28);
  assign pn7_v  = pn7_q[DW-1:0];
  assign pn15_v = pn15_q[DW-1:0];
  assign pn31_v = pn31_q[DW-1:0];
  assign ramp_d = ramp_q + 16'(DPW) * dac_ramp_incr;
  assign dma_sel = (sel_q == 4'd2);

  always_comb begin
    data_d = '0;
    lane   = '0;
    for (int k = 0; k < DPW; k++) begin
      lane = '0;
      unique case (sel_q)
        4'd0: lane = dds_data[16*k +: 16];
        4'd1: lane = k[0] ? dac_pat_data_1 : dac_pat_data_0;
        4'd2: lane = dma_valid ? dma_data[16*k +: 16] : 16'h0;
        4'd4: lane = ~pn7_v[16*(DPW-1-k) +: 16];
        4'd5: lane = ~pn15_v[16*(DPW-1-k) +: 16];
        4'd6: lane = pn7_v[16*(DPW-1-k) +: 16];
        4'd7: lane = pn15_v[16*(DPW-1-k) +: 16];
        4'd8: lane = ramp_q + 16'(k) * dac_ramp_incr;
        4'd9: lane = pn31_v[16*(DPW-1-k) +: 16];
        default: lane = '0;
      endcase
      data_d[16*k +: 16] = lane & MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= 4'd3;
      data_q <= '0;
      en_q   <= 1'b0;
      unf_q  <= 1'b0;
      pn7_q  <= '1;
      pn15_q <= '1;
      pn31_q <= '1;
      ramp_q <= '0;
    end else begin
      if (dac_data_sync || !SEL_ON_SYNC)
        sel_q <= dac_data_sel;
      data_q <= data_d;
      en_q   <= dma_sel;
      // a new gap outranks a clear in the same cycle
      if (dma_sel && !dma_valid)
        unf_q <= 1'b1;
      else if (dac_underflow_clr)
        unf_q <= 1'b0;
      if (dac_data_sync) begin
        pn7_q  <= '1;
        pn15_q <= '1;
        pn31_q <= '1;
        ramp_q <= '0;
      end else begin
        pn7_q  <= pn7_e[W7-1:0];
        pn15_q <= pn15_e[W15-1:0];
        pn31_q <= pn31_e[W31-1:0];
        ramp_q <= ramp_d;
      end
    end
  end

  assign dma_ready     = !rst && dma_sel;
  assign dac_data      = data_q;
  assign dac_enable    = en_q;
  assign dac_underflow = unf_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_pattern_channel.sv
// tb_ad_ip_jesd204_tpl_dac_pattern_channel
// Vector table, corner sequences and random run against a stream model.
module tb_ad_ip_jesd204_tpl_dac_pattern_channel;
  localparam int DPW = 4;
  localparam int N   = 14;
  localparam logic [15:0] M = 16'hFFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        sync;
  logic [3:0]  sel;
  logic [15:0] pat0, pat1, incr;
  logic [63:0] dds, dma, dout;
  logic        valid, ready, clr, en, unf;

  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_dac_pattern_channel #(
    .DATA_PATH_WIDTH(DPW),
    .CONVERTER_RESOLUTION(N),
    .SEL_ON_SYNC(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dac_data_sync(sync),
    .dac_data_sel(sel),
    .dac_pat_data_0(pat0),
    .dac_pat_data_1(pat1),
    .dac_ramp_incr(incr),
    .dds_data(dds),
    .dma_data(dma),
    .dma_valid(valid),
    .dma_ready(ready),
    .dac_underflow_clr(clr),
    .dac_data(dout),
    .dac_enable(en),
    .dac_underflow(unf)
  );

  int checks = 0;
  int failures = 0;

  // model: active select, PN stream bits of the current beat
  // (index 0 = first stream bit), ramp sample accumulator
  logic [3:0]  m_sel;
  logic [15:0] m_acc;
  logic        m_unf, m_en;
  logic [63:0] e_data;
  bit          pnb[3][64];
  int          pl[3] = '{7, 15, 31};
  int          pt[3] = '{6, 14, 28};

  function automatic void pn_reset();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 64; i++) pnb[p][i] = 1'b1;
  endfunction

  function automatic void pn_advance();
    bit t[128];
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 64; i++) t[i] = pnb[p][i];
      for (int i = 64; i < 128; i++)
        t[i] = t[i-pl[p]] ^ t[i-pt[p]];
      for (int i = 0; i < 64; i++) pnb[p][i] = t[64+i];
    end
  endfunction

  function automatic logic [15:0] pn_lane(int p, int j);
    logic [15:0] v;
    v = '0;
    for (int b = 0; b < 16; b++) v = {v[14:0], pnb[p][16*j+b]};
    return v;
  endfunction

  task automatic model_edge();
    logic [15:0] l;
    logic [15:0] acc;
    e_data = '0;
    if (rst) begin
      m_sel = 4'd3;
      m_acc = '0;
      m_unf = 1'b0;
      m_en  = 1'b0;
      pn_reset();
      return;
    end
    acc = m_acc;
    for (int k = 0; k < 4; k++) begin
      case (m_sel)
        4'd0: l = dds[16*k +: 16];
        4'd1: l = (k % 2 == 1) ? pat1 : pat0;
        4'd2: l = valid ? dma[16*k +: 16] : 16'h0;
        4'd4: l = ~pn_lane(0, k);
        4'd5: l = ~pn_lane(1, k);
        4'd6: l = pn_lane(0, k);
        4'd7: l = pn_lane(1, k);
        4'd8: l = acc;
        4'd9: l = pn_lane(2, k);
        default: l = 16'h0;
      endcase
      acc = acc + incr;
      e_data[16*k +: 16] = l & M;
    end
    if (m_sel == 4'd2 && !valid) m_unf = 1'b1;
    else if (clr) m_unf = 1'b0;
    m_en = (m_sel == 4'd2);
    if (sync) begin
      m_sel = sel;
      m_acc = '0;
      pn_reset();
    end else begin
      m_acc = acc;
      pn_advance();
    end
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("model_data", dout, e_data);
    check("model_underflow", 64'(unf), 64'(m_unf));
    check("model_enable", 64'(en), 64'(m_en));
    check("model_ready", 64'(ready), 64'(!rst && m_sel == 4'd2));
  endtask

  typedef struct {
    string       name;
    logic [3:0]  sel;
    logic [15:0] p0;
    logic [15:0] p1;
    logic [63:0] dds;
    logic [63:0] exp;
  } vec_t;

  vec_t tv[5];
  logic [3:0] pn_sels[5] = '{4'd6, 4'd7, 4'd9, 4'd4, 4'd5};

  initial begin
    tv[0] = '{"pattern_a5", 4'd1, 16'hA5A5, 16'h5A5A, 64'h0,
              64'h5A58_A5A4_5A58_A5A4};
    tv[1] = '{"pattern_ff", 4'd1, 16'hFFFF, 16'h0001, 64'h0,
              64'h0000_FFFC_0000_FFFC};
    tv[2] = '{"dds", 4'd0, 16'h0, 16'h0, 64'hDEF1_9ABC_5678_1234,
              64'hDEF0_9ABC_5678_1234};
    tv[3] = '{"zero3", 4'd3, 16'hFFFF, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h0};
    tv[4] = '{"zero12", 4'd12, 16'hFFFF, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h0};

    rst = 1'b1; sync = 1'b0; sel = 4'd0; pat0 = '0; pat1 = '0;
    incr = '0; dds = '0; dma = '0; valid = 1'b0; clr = 1'b0;
    tick();
    check("reset_data", dout, 64'h0);
    check("reset_underflow", 64'(unf), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    check("reset_zero_source", dout, 64'h0);

    foreach (tv[i]) begin
      sel = tv[i].sel; pat0 = tv[i].p0; pat1 = tv[i].p1; dds = tv[i].dds;
      sync = 1'b1; tick();
      sync = 1'b0; tick();
      check(tv[i].name, dout, tv[i].exp);
    end

    sel = 4'd8; incr = 16'h0010; sync = 1'b1; tick();
    sync = 1'b0; tick();
    check("ramp_beat0", dout, 64'h0030_0020_0010_0000);
    tick();
    check("ramp_beat1", dout, 64'h0070_0060_0050_0040);
    incr = 16'h4000; sync = 1'b1; tick();
    sync = 1'b0; tick();
    check("ramp_wrap0", dout, 64'hC000_8000_4000_0000);
    tick();
    check("ramp_wrap1", dout, 64'hC000_8000_4000_0000);

    foreach (pn_sels[s]) begin
      sel = pn_sels[s]; sync = 1'b1; tick();
      sync = 1'b0; tick();
      check("pn_first_beat", dout,
            (pn_sels[s] >= 4'd6) ? 64'hFFFC_FFFC_FFFC_FFFC : 64'h0);
      for (int b = 0; b < 255; b++) begin
        dds = {$urandom, $urandom};
        dma = {$urandom, $urandom};
        tick();
      end
    end

    sel = 4'd3; sync = 1'b1; tick();
    sync = 1'b0; tick();
    sel = 4'd2; valid = 1'b1; dma = 64'h1111_2222_3333_4444;
    tick(); tick();
    check("nosync_data", dout, 64'h0);
    check("nosync_ready", 64'(ready), 64'h0);
    sync = 1'b1; tick();
    check("sync_ready", 64'(ready), 64'h1);
    sync = 1'b0; tick();
    check("dma_data", dout, 64'h1110_2220_3330_4444);
    check("dma_enable", 64'(en), 64'h1);

    valid = 1'b0; dma = 64'h1234_1234_1234_1234; tick();
    check("gap_data", dout, 64'h0);
    check("gap_underflow", 64'(unf), 64'h1);
    valid = 1'b1; tick();
    check("underflow_sticky", 64'(unf), 64'h1);
    check("after_gap_data", dout, 64'h1234_1234_1234_1234);
    clr = 1'b1; tick();
    check("underflow_clr", 64'(unf), 64'h0);
    valid = 1'b0; tick();
    check("set_beats_clr", 64'(unf), 64'h1);
    clr = 1'b0; tick();
    rst = 1'b1; tick();
    check("rst_mid_data", dout, 64'h0);
    check("rst_mid_underflow", 64'(unf), 64'h0);
    check("rst_mid_enable", 64'(en), 64'h0);
    rst = 1'b0; valid = 1'b1; sel = 4'd2; tick();
    check("rst_sel_ready", 64'(ready), 64'h0);
    tick();
    check("rst_sel_data", dout, 64'h0);

    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 63) == 0);
      sync  = ($urandom_range(0, 7) == 0);
      sel   = 4'($urandom_range(0, 15));
      valid = ($urandom_range(0, 3) != 0);
      clr   = ($urandom_range(0, 7) == 0);
      dds   = {$urandom, $urandom};
      dma   = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) begin
        pat0 = 16'($urandom);
        pat1 = 16'($urandom);
        incr = 16'($urandom);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
